mul_sequencer: RTL

MUL_SEQUENCER -- requirements
Module: mul_sequencer

---
 rtl/mul_sequencer.sv | 107 ++++++++++
 1 files changed

// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - iterative shift-add multiplier with pipeline stall/flush handshake
// Optional signed support when MUL_SIGNED_EN is defined (sign-magnitude, negate on RUN->DONE).
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module mul_sequencer #(
  parameter int WORD_LEN = `WORD_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                flush,
  input  logic                is_signed,
  input  logic [WORD_LEN-1:0] op_a,
  input  logic [WORD_LEN-1:0] op_b,
  output logic                stall,
  output logic                busy,
  output logic                done,
  output logic [WORD_LEN-1:0] result_lo,
  output logic [WORD_LEN-1:0] result_hi
);

  localparam int CW = $clog2(WORD_LEN + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_next;
  logic [WORD_LEN-1:0]   mcand, mplier;
  logic [2*WORD_LEN-1:0] acc, acc_step, acc_final, result_q;
  logic [CW-1:0]         count;
  logic [WORD_LEN:0]     sum;
  logic [WORD_LEN-1:0]   a_mag, b_mag;
  logic                  accept, last;

  assign accept = (state == IDLE) && start && !flush;
  assign last   = (count == CW'(WORD_LEN - 1));

  // Carry out of the upper-half add becomes the new MSB after the shift.
  assign sum      = {1'b0, acc[2*WORD_LEN-1:WORD_LEN]} + {1'b0, (mplier[0] ? mcand : '0)};
  assign acc_step = {sum, acc[WORD_LEN-1:1]};

`ifdef MUL_SIGNED_EN
  logic neg;
  // Magnitude of the most negative value is representable as an unsigned word.
  assign a_mag     = (is_signed && op_a[WORD_LEN-1]) ? -op_a : op_a;
  assign b_mag     = (is_signed && op_b[WORD_LEN-1]) ? -op_b : op_b;
  assign acc_final = neg ? -acc_step : acc_step;
`else
  logic unused_sign;
  assign unused_sign = is_signed;
  assign a_mag       = op_a;
  assign b_mag       = op_b;
  assign acc_final   = acc_step;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (flush) state_next = IDLE;
               else if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stall = !rst && (accept || (state == RUN));
    busy  = (state == RUN) || (state == DONE);
    done  = (state == DONE) && !flush;
    // The new product is visible during the done pulse and held afterwards.
    {result_hi, result_lo} = done ? acc : result_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      count    <= '0;
      result_q <= '0;
`ifdef MUL_SIGNED_EN
      neg      <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (accept) begin
        mcand  <= a_mag;
        mplier <= b_mag;
        acc    <= '0;
        count  <= '0;
`ifdef MUL_SIGNED_EN
        neg    <= is_signed && (op_a[WORD_LEN-1] ^ op_b[WORD_LEN-1]);
`endif
      end else if (state == RUN && !flush) begin
        acc    <= last ? acc_final : acc_step;
        mplier <= mplier >> 1;
        count  <= count + 1'b1;
      end else if (state == DONE && !flush) begin
        result_q <= acc;
      end
    end
  end

endmodule
